sync_clk_fast_to_slow: RTL and testbench
========================================

SYNC_CLK_FAST_TO_SLOW -- requirements
Module: sync_clk_fast_to_slow

Interface
REQ-001 Parameter SYNC_STAGES, default 2, SHALL set the synchronizer depth in both directions; legal values are >= 2.
REQ-002 The module SHALL use one clock and a synchronous, active-high reset, on ports clk and rst.
REQ-003 clk  input  1  single clock; all registers update on its rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 slow_en  input  1  slow-domain tick; qualifies every slow-side register, one clk cycle wide per slow period.
REQ-006 signal_in  input  1  fast-side pulse request, one or more clk cycles high.
REQ-007 signal_out  output  1  slow-side pulse, high for exactly one slow period per accepted request.
REQ-008 busy  output  1  high while a request is in flight; new requests are rejected.
REQ-009 drop  output  1  one-cycle flag marking a rejected request.

Function
REQ-010 Fast side SHALL hold toggle register req_tgl; when signal_in=1 and busy=0, req_tgl SHALL invert at the next clk edge (request accepted).
REQ-011 busy SHALL be combinational req_tgl XOR ack_sync, where ack_sync is the last stage of a SYNC_STAGES flop chain clocked every clk and fed from ack_tgl.
REQ-012 When signal_in=1 and busy=1, req_tgl SHALL NOT change, and drop SHALL be registered high for the following single clk cycle; otherwise drop=0.
REQ-013 Slow side SHALL hold a SYNC_STAGES flop chain sync[0..N-1] and register slow_prev; all of these shift only on clk edges where slow_en=1.
REQ-014 On each such edge: sync[0]<=req_tgl, sync[i]<=sync[i-1], slow_prev<=sync[N-1].
REQ-015 signal_out SHALL equal sync[N-1] XOR slow_prev, so it changes only on slow_en edges and stays high for exactly one slow period.
REQ-016 ack_tgl SHALL be slow_prev, fed back to the fast-side synchronizer.
REQ-017 Latency: signal_out SHALL rise on the SYNC_STAGES-th slow_en edge after the req_tgl toggle edge.
REQ-018 busy SHALL fall SYNC_STAGES clk cycles after the slow_en edge on which signal_out falls.
REQ-019 signal_in held high for several cycles SHALL be accepted once, in the first cycle. Each later cycle while busy=1 SHALL be dropped (drop pulses each such cycle).
REQ-020 slow_en tied high SHALL be legal; signal_out is then one clk cycle wide.
REQ-021 slow_en=0 indefinitely SHALL freeze the slow side; busy stays high and no signal_out occurs.
REQ-022 Exactly one signal_out pulse SHALL be produced per accepted request; no pulse is lost or duplicated.

Reset
REQ-023 With rst=1 at a clk edge, req_tgl, both synchronizer chains, slow_prev and drop SHALL clear to 0, independent of slow_en.
REQ-024 During and after reset, signal_out=0, busy=0 and drop=0.
REQ-025 rst asserted mid-transfer SHALL abort the transfer: no signal_out pulse follows, and busy=0 once rst deasserts.
REQ-026 signal_in SHALL be ignored while rst=1.

Verification
(Defaults, unless a scenario states otherwise: SYNC_STAGES=2, slow_en high one cycle in every 3 clk cycles.)
REQ-027 Reset: rst=1 for 2 cycles, signal_in toggling -> signal_out=0, busy=0, drop=0 throughout.
REQ-028 Single pulse:
- Stimulus: signal_in=1 for one cycle, 5 cycles after reset.
- signal_out: high for exactly 3 clk cycles, once, rising on the 2nd slow_en edge after acceptance.
- busy: low 2 cycles after signal_out falls.
REQ-029 Held input: signal_in=1 for 2 consecutive cycles -> one signal_out pulse; drop=1 for exactly one cycle.
REQ-030 Back-to-back: second single-cycle pulse issued after busy=0 -> second 3-cycle signal_out pulse. Same pulse issued while busy=1 -> drop=1 and no extra signal_out.
REQ-031 Abort: rst=1 for one cycle between acceptance and the signal_out rise -> no signal_out pulse; busy=0 after reset.
REQ-032 slow_en tied high: single pulse -> signal_out high exactly 1 cycle, rising 2 cycles after acceptance.

Source files
------------

// File: rtl/sync_clk_fast_to_slow_if.sv
// Purpose: bundles the pulse-synchronizer request/response signals between a fast-side
//          requester (master) and the synchronizer (slave).
// Ports:   signal_in (master->slave) pulse request; signal_out, busy, drop (slave->master).
interface sync_clk_fast_to_slow_if;
  logic signal_in;   // fast-side pulse request
  logic signal_out;  // slow-side pulse, one slow period per accepted request
  logic busy;        // request in flight; new requests are rejected
  logic drop;        // one-cycle flag for a rejected request

  modport master (
    output signal_in,
    input  signal_out,
    input  busy,
    input  drop
  );

  modport slave (
    input  signal_in,
    output signal_out,
    output busy,
    output drop
  );
endinterface

// File: rtl/sync_clk_fast_to_slow.sv
// Purpose: toggle-based pulse transfer from the fast clk rate to a slow_en-qualified slow domain.
// Latency: signal_out rises on the SYNC_STAGES-th slow_en edge after acceptance; busy clears SYNC_STAGES clk after it falls.
// Backpressure: busy blocks new requests; a request seen while busy is rejected and flagged on drop for one cycle.
// Ports: clk, rst (sync, active high), slow_en (slow tick),
//        bus.slave: signal_in -> signal_out, busy, drop.
module sync_clk_fast_to_slow #(
  parameter int SYNC_STAGES = 2  // synchronizer depth in both directions, >= 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   slow_en,
  sync_clk_fast_to_slow_if.slave bus
);

  // Fast side state
  logic                   req_tgl_q,  req_tgl_d;
  logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
  logic                   drop_q,     drop_d;

  // Slow side state (only advances on slow_en)
  logic [SYNC_STAGES-1:0] sync_q,      sync_d;
  logic                   slow_prev_q, slow_prev_d;

  logic busy;
  logic accept;

  // A request is outstanding until the slow side's acknowledge toggle has
  // travelled back through the fast-side synchronizer and matches req_tgl.
  assign busy   = req_tgl_q ^ ack_sync_q[SYNC_STAGES-1];
  assign accept = bus.signal_in & ~busy;

  always_comb begin
    req_tgl_d   = req_tgl_q ^ accept;
    drop_d      = bus.signal_in & busy;
    // ack_tgl is slow_prev: it flips exactly when the slow pulse ends, so busy
    // covers the whole slow-side pulse plus the return synchronization.
    ack_sync_d  = {ack_sync_q[SYNC_STAGES-2:0], slow_prev_q};

    sync_d      = sync_q;
    slow_prev_d = slow_prev_q;
    if (slow_en) begin
      sync_d      = {sync_q[SYNC_STAGES-2:0], req_tgl_q};
      slow_prev_d = sync_q[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_tgl_q   <= 1'b0;
      ack_sync_q  <= '0;
      drop_q      <= 1'b0;
      sync_q      <= '0;
      slow_prev_q <= 1'b0;
    end else begin
      req_tgl_q   <= req_tgl_d;
      ack_sync_q  <= ack_sync_d;
      drop_q      <= drop_d;
      sync_q      <= sync_d;
      slow_prev_q <= slow_prev_d;
    end
  end

  // Edge detect on the synchronized toggle: high for one full slow period.
  assign bus.signal_out = sync_q[SYNC_STAGES-1] ^ slow_prev_q;
  assign bus.busy       = busy;
  assign bus.drop       = drop_q;

endmodule

// File: tb/tb_sync_clk_fast_to_slow.sv
module tb_sync_clk_fast_to_slow;
  localparam int N     = 2;
  localparam int NEVER = 32'h3fffffff;

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic slow_en = 1'b0;

  sync_clk_fast_to_slow_if bus_if();

  sync_clk_fast_to_slow #(.SYNC_STAGES(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .slow_en(slow_en),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  // cyc = index of the most recent rising edge (first edge is 1)
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // slow_en schedule: mode 0 = one edge in three (phase selects which),
  // mode 1 = tied high, mode 2 = frozen low
  int mode  = 0;
  int phase = 0;

  typedef struct {
    int rise;  // edge after which signal_out is first high
    int fall;  // edge after which signal_out is low again
    int off;   // edge after which busy is low again
  } exp_t;

  exp_t pq[$];       // expected pulses, in order
  int   dq[$];       // edges at which a drop is expected
  bit   in_flight = 1'b0;
  int   busy_off  = 0;
  int   n_acc     = 0;
  int   n_seen    = 0;

  function automatic bit en_at(int k);
    case (mode)
      0:       return (k % 3) == phase;
      1:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Edge index of the n-th slow tick strictly after edge a.
  function automatic int nth_en_after(int a, int n);
    int k = a;
    int c = 0;
    while (c < n) begin
      k++;
      if (en_at(k)) c++;
      if (k > a + 1000) return NEVER;
    end
    return k;
  endfunction

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one clock: inputs applied at the falling edge, model updated for the next rising edge.
  task automatic tick(bit sin, bit r);
    int   k;
    exp_t e;
    @(negedge clk);
    k = cyc + 1;
    bus_if.signal_in = sin;
    rst              = r;
    slow_en          = en_at(k);
    if (r) begin
      n_acc     -= pq.size();
      in_flight  = 1'b0;
      pq.delete();
      dq.delete();
    end else if (sin) begin
      if (in_flight && k <= busy_off) begin
        dq.push_back(k);
      end else begin
        e.rise = nth_en_after(k, N);
        e.fall = (e.rise == NEVER) ? NEVER : nth_en_after(e.rise, 1);
        e.off  = (e.fall == NEVER) ? NEVER : e.fall + N;
        pq.push_back(e);
        in_flight = 1'b1;
        busy_off  = e.off;
        n_acc++;
      end
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && in_flight && (cyc + 1) <= busy_off; i++) tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic set_mode(int m, int p);
    wait_idle();
    mode  = m;
    phase = p;
    tick(1'($urandom_range(0, 1)), 1'b1);
    tick(1'($urandom_range(0, 1)), 1'b1);
    tick(1'b0, 1'b0);
  endtask

  // Monitor: compares every observed output event against the scoreboard queues.
  initial begin : monitor
    bit   po;
    bit   pb;
    bit   have;
    exp_t cur;
    int   k;
    po   = 1'b0;
    pb   = 1'b0;
    have = 1'b0;
    cur  = '{default: 0};
    forever begin
      @(posedge clk);
      #1;
      k = cyc;
      if (rst) begin
        check("reset_outputs", int'({bus_if.signal_out, bus_if.busy, bus_if.drop}), 0);
        po   = 1'b0;
        pb   = 1'b0;
        have = 1'b0;
      end else begin
        while (pq.size() > 0 && pq[0].rise < k) begin
          check("pulse_missing_rise_edge", -1, pq[0].rise);
          void'(pq.pop_front());
        end
        if (bus_if.signal_out && !po) begin
          n_seen++;
          if (pq.size() == 0) begin
            check("unexpected_pulse_edge", k, -1);
          end else begin
            cur  = pq.pop_front();
            have = 1'b1;
            check("pulse_rise_edge", k, cur.rise);
          end
        end
        if (!bus_if.signal_out && po && have) check("pulse_fall_edge", k, cur.fall);
        if (!bus_if.busy && pb) begin
          if (have) check("busy_fall_edge", k, cur.off);
          else      check("busy_fall_without_pulse", k, -1);
          have = 1'b0;
        end
        while (dq.size() > 0 && dq[0] < k) begin
          check("drop_missing_edge", -1, dq[0]);
          void'(dq.pop_front());
        end
        if (bus_if.drop) begin
          if (dq.size() == 0) check("unexpected_drop_edge", k, -1);
          else                check("drop_edge", k, dq.pop_front());
        end
        po = bus_if.signal_out;
        pb = bus_if.busy;
      end
    end
  end

  initial begin : stimulus
    bus_if.signal_in = 1'b0;

    // Reset with signal_in toggling
    mode  = 0;
    phase = 0;
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);

    // Single pulse, 5 cycles after reset
    idle(5);
    tick(1'b1, 1'b0);
    idle(15);

    // Held input: accepted once, dropped once
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    idle(15);

    // Back-to-back after busy clears, then a request while busy
    tick(1'b1, 1'b0);
    wait_idle();
    tick(1'b1, 1'b0);
    idle(3);
    tick(1'b1, 1'b0);
    idle(15);

    // Abort between acceptance and the output rise
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    idle(10);
    check("abort_busy", int'(bus_if.busy), 0);
    check("abort_signal_out", int'(bus_if.signal_out), 0);
    idle(10);

    // Other slow tick phases
    for (int p = 1; p < 3; p++) begin
      set_mode(0, p);
      tick(1'b1, 1'b0);
      idle(12);
    end

    // slow_en tied high
    set_mode(1, 0);
    tick(1'b1, 1'b0);
    idle(8);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    idle(8);

    // Randomized traffic, tick every third cycle then tied high
    set_mode(0, int'($urandom_range(0, 2)));
    for (int i = 0; i < 300; i++) tick(1'($urandom_range(0, 3) == 0), 1'b0);
    set_mode(1, 0);
    for (int i = 0; i < 300; i++) tick(1'($urandom_range(0, 2) == 0), 1'b0);

    // Frozen slow side: stays busy, no output; reset clears it
    set_mode(2, 0);
    tick(1'b1, 1'b0);
    idle(30);
    check("freeze_busy", int'(bus_if.busy), 1);
    check("freeze_signal_out", int'(bus_if.signal_out), 0);
    set_mode(0, 0);
    idle(5);
    check("after_freeze_busy", int'(bus_if.busy), 0);

    // Drain and reconcile
    wait_idle();
    idle(5);
    check("pending_pulses", pq.size(), 0);
    check("pending_drops", dq.size(), 0);
    check("pulse_count", n_seen, n_acc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
